// File: rtl/weight_stream_pkg.sv
// Shared widths and the storage beat type for the weight stream FIFO.
package weight_stream_pkg;

    localparam int unsigned DEFAULT_PRECISION   = 16;
    localparam int unsigned DEFAULT_PARALLELISM = 1;

    // Storage-only beat type; ports stay unpacked arrays.
    typedef logic [DEFAULT_PARALLELISM*DEFAULT_PRECISION-1:0] weight_beat_t;

    // Index width for a modulo-n counter; never collapses below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return idx_width(depth);
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/weight_stream_fifo_mem.sv
// Storage array: one write port, one asynchronous read port, contents not reset.
module weight_stream_fifo_mem
    import weight_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = ptr_width(DEPTH),
    parameter type         beat_t = weight_beat_t
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  beat_t            wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output beat_t            rd_data
);

    beat_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/weight_stream_fifo.sv
// Elastic weight buffer with registered FWFT output between a weight source and its consumer.
// Define WEIGHT_STREAM_FIFO_LAST_EN to build the pass beat counter and the data_out_last port.
module weight_stream_fifo
    import weight_stream_pkg::*;
#(
    parameter int unsigned WEIGHT_PRECISION_0       = 16,
    parameter int unsigned WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int unsigned WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int unsigned OUT_DEPTH                = 32,
    parameter int unsigned FIFO_DEPTH               = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WEIGHT_PRECISION_0-1:0] data_in [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0],
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic [WEIGHT_PRECISION_0-1:0] data_out [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0],
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
`ifdef WEIGHT_STREAM_FIFO_LAST_EN
    output logic                          data_out_last,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned P      = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
    localparam int unsigned BEAT_W = P * WEIGHT_PRECISION_0;
    localparam int unsigned PTR_W  = ptr_width(FIFO_DEPTH);
    localparam int unsigned OCC_W  = occ_width(FIFO_DEPTH);

    typedef logic [BEAT_W-1:0] beat_t;

    if (OUT_DEPTH < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("weight_stream_fifo: OUT_DEPTH must be >= 1 and FIFO_DEPTH a power of two >= 2");
    end

    beat_t            in_beat;
    beat_t            mem_rd;
    beat_t            head_beat;
    beat_t            out_beat;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [OCC_W-1:0] remain;
    logic [OCC_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             bypass;

    for (genvar i = 0; i < P; i++) begin : g_lane
        assign in_beat[i*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0] = data_in[i];
        assign data_out[i] = out_beat[i*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
    end

    assign push = data_in_valid && data_in_ready;
    assign pop  = data_out_valid && data_out_ready;

    // Next head: the beat written this cycle when nothing older survives the pop.
    always_comb begin
        remain      = count - OCC_W'(pop);
        count_next  = remain + OCC_W'(push);
        rd_ptr_next = rd_ptr + PTR_W'(pop);
        bypass      = push && (remain == '0);
        head_beat   = bypass ? in_beat : mem_rd;
    end

    weight_stream_fifo_mem #(
        .DEPTH  (FIFO_DEPTH),
        .PTR_W  (PTR_W),
        .beat_t (beat_t)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_beat),
        .rd_addr (rd_ptr_next),
        .rd_data (mem_rd)
    );

    // Output register holds its value whenever the FIFO drains empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_in_ready  <= 1'b0;
            data_out_valid <= 1'b0;
            out_beat       <= '0;
        end else begin
            wr_ptr         <= wr_ptr + PTR_W'(push);
            rd_ptr         <= rd_ptr_next;
            count          <= count_next;
            data_in_ready  <= count_next < OCC_W'(FIFO_DEPTH);
            data_out_valid <= count_next != '0;
            if (count_next != '0) begin
                out_beat <= head_beat;
            end
        end
    end

`ifdef WEIGHT_STREAM_FIFO_LAST_EN
    localparam int unsigned BEAT_CW = idx_width(OUT_DEPTH);

    logic [BEAT_CW-1:0] beat;
    logic [BEAT_CW-1:0] beat_next;

    // Pass position of the beat that will sit at the head after this cycle.
    always_comb begin
        beat_next = beat;
        if (pop) begin
            beat_next = (beat == BEAT_CW'(OUT_DEPTH - 1)) ? '0 : beat + BEAT_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat          <= '0;
            data_out_last <= 1'b0;
        end else begin
            beat          <= beat_next;
            data_out_last <= (count_next != '0) && (beat_next == BEAT_CW'(OUT_DEPTH - 1));
        end
    end
`endif

endmodule

// File: doc/weight_stream_fifo.md
# weight_stream_fifo

Elastic buffer placed directly downstream of a `*_weight_source` block, between it and the linear/matmul stage that consumes weights. The source's ROM has a two-cycle read pipeline and advances its address on `data_out_ready` alone. This block registers each accepted weight beat and provides a clean valid/ready stream with backpressure. It also tags the final beat of every `OUT_DEPTH`-beat weight pass.

## Interface
Parameters:
- `WEIGHT_PRECISION_0`, 16: bits per weight element.
- `WEIGHT_PARALLELISM_DIM_0`, 1: elements per beat, dim 0.
- `WEIGHT_PARALLELISM_DIM_1`, 1: elements per beat, dim 1.
- `OUT_DEPTH`, 32: beats per full weight pass, ≥1.
- `FIFO_DEPTH`, 4: storage entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous active-high reset.
- `data_in`, in, `WEIGHT_PRECISION_0` × P: weight beat from the source. P = `WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1`; unpacked array [P-1:0].
- `data_in_valid`, in, 1: upstream beat valid.
- `data_in_ready`, out, 1: this block can accept a beat.
- `data_out`, out, `WEIGHT_PRECISION_0` × P: head beat.
- `data_out_valid`, out, 1: head beat valid.
- `data_out_ready`, in, 1: downstream accepts the head beat.
- `data_out_last`, out, 1: head beat is beat `OUT_DEPTH-1` of the current pass. Present only when the macro is defined.
- `count`, out, `$clog2(FIFO_DEPTH)+1`: current occupancy.

## Operation
- Push occurs when `data_in_valid && data_in_ready`. Pop occurs when `data_out_valid && data_out_ready`.
- `data_in_ready` = registered, equals `count < FIFO_DEPTH` evaluated after this cycle's push/pop.
- First-word-fall-through from an output register. `data_out` and `data_out_valid` are registered and never combinational from `data_in`.
- Order is strictly preserved. No beat is dropped or duplicated.
- Full: `data_in_ready` = 0. A simultaneous pop on the full cycle raises `data_in_ready` on the next cycle; there is no same-cycle bypass.
- Empty: `data_out_valid` = 0. A push into an empty FIFO appears at `data_out` on the next cycle.
- Simultaneous push and pop at nonzero occupancy: `count` is unchanged and the pointers both advance.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`.
- Beat counter (macro on) counts pops from 0 to `OUT_DEPTH-1`, then wraps to 0.
  - `data_out_last` = `data_out_valid && beat == OUT_DEPTH-1`.
  - With `OUT_DEPTH` = 1, every valid beat is last.
- `data_out` contents while `data_out_valid` = 0 are don't-care, but must be held stable, not X, after reset.

## Timing
- Reset values: `data_in_ready` = 0, `data_out_valid` = 0, `data_out` = all 0, `count` = 0, `data_out_last` = 0, pointers and beat counter = 0.
- `data_in_ready` rises at the first rising edge after `rst` deasserts.
- Latency from push to `data_out_valid` is 1 cycle when the FIFO is empty.
- Throughput is 1 beat/cycle sustained when downstream is always ready.
- `data_out`, `data_out_valid` and `data_out_last` are held stable while `data_out_valid && !data_out_ready`.
- Reset asserted mid-operation discards all contents immediately (asynchronously). The beat counter restarts at 0.

## Configuration
- `WEIGHT_STREAM_FIFO_LAST_EN` defined: the beat counter is built and the `data_out_last` port exists.
- Not defined: no beat counter and no `data_out_last` port. All other behaviour is identical.

## Structure
- Package `weight_stream_pkg` holds:
  - the occupancy-width and pointer-width helper constants;
  - a `weight_beat_t` packed typedef, P × `WEIGHT_PRECISION_0`. It is used for storage only; ports stay unpacked arrays for cocotb/verilator.
- One sub-module, `weight_stream_fifo_mem`: a `FIFO_DEPTH`-entry register array with 1 write port, 1 asynchronous read port, and no reset on contents.
- The top holds pointers, occupancy, the output register, handshake logic and the beat counter.

## Test plan
- Reset with `FIFO_DEPTH`=4, then stream 8 beats 0x0001..0x0008 with `data_out_ready`=1. Required: outputs 0x0001..0x0008 in order, each one cycle after its push, and `count` never exceeds 1.
- Hold `data_out_ready`=0 and push 0x0010..0x0014. Required: four beats are accepted, `data_in_ready` = 0 after the fourth, `count` = 4, and 0x0014 is stalled upstream. Release ready: 0x0010..0x0014 emerge in order.
- At full, assert pop and push on the same cycle. Required: the push is refused, `count` goes to 3, and `data_in_ready` = 1 on the next cycle.
- Macro on, `OUT_DEPTH`=32, 70 continuous beats. Required: `data_out_last` high on output beats 31 and 63 only, and the counter wraps cleanly.
- Mid-stream with `count`=3, pulse `rst` asynchronously. Required: `data_out_valid` and `count` are 0 immediately, and `data_in_ready` stays 0 until the first edge after release. The next beat out is the first beat pushed after release, with beat index 0.
- Random `data_in_valid`/`data_out_ready` at 50% for 10,000 cycles. Required: a scoreboard sees zero loss, duplication or reordering, and `data_out` is stable under stall.
